// File: rtl/ifu_pkg.sv
// Shared CPU fetch-side constants: reset PC, instruction-memory geometry,
// the NOP/bubble encoding and the IF/ID pipeline-register layout.
package ifu_pkg;

  localparam logic [31:0] START_ADDR_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT   = 1024;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

  typedef logic [31:0] im_addr_t;
  typedef logic [31:0] im_word_t;

  typedef struct packed {
    logic     valid;
    im_word_t instr;
    im_addr_t pc;
    im_addr_t pc_plus4;
    logic     fetch_err;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    valid:     1'b0,
    instr:     NOP_INSTR,
    pc:        '0,
    pc_plus4:  '0,
    fetch_err: 1'b0
  };

  // limit is one past the last legal byte; 33 bits so a window ending at 2^32 still works
  function automatic logic fetch_fault(input im_addr_t pc, input im_addr_t start,
                                       input logic [32:0] limit);
    return (pc[1:0] != 2'b00) || (pc < start) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: hazard/branch controls in, instruction-memory port, IF/ID outputs.
interface ifu_if;
  import ifu_pkg::*;

  logic     stall;
  logic     redirect;
  im_addr_t redirect_target;
  logic     flush;
  im_addr_t im_addr;
  logic     im_enable;
  im_word_t im_data;
  logic     id_valid;
  im_word_t id_instr;
  im_addr_t id_pc;
  im_addr_t id_pc_plus4;
  logic     id_fetch_err;

  modport master (
    input  stall, redirect, redirect_target, flush, im_data,
    output im_addr, im_enable, id_valid, id_instr, id_pc, id_pc_plus4, id_fetch_err
  );

  modport slave (
    output stall, redirect, redirect_target, flush, im_data,
    input  im_addr, im_enable, id_valid, id_instr, id_pc, id_pc_plus4, id_fetch_err
  );
endinterface

// File: rtl/ifu_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise capture.
module if_id_reg
  import ifu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t cap_i,
  output if_id_t id_o
);

  if_id_t id_q, id_d;

  // NOTE: default to the held value first so no path through this block infers a latch.
  always_comb begin
    id_d = id_q;
    if (flush_i) begin
      id_d = IF_ID_BUBBLE;
    end else if (!stall_i) begin
      id_d = cap_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= IF_ID_BUBBLE;
    end else begin
      id_q <= id_d;
    end
  end

  assign id_o = id_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, next-PC selection, fetch range check,
// and the IF/ID register that hands the fetched word to decode.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] START_ADDR = START_ADDR_DEFAULT,
  parameter int unsigned IM_WORDS   = IM_WORDS_DEFAULT
) (
  input logic   clk,
  input logic   rst_n,
  ifu_if.master bus
);

  localparam logic [32:0] END_ADDR = {1'b0, START_ADDR} + (33'(IM_WORDS) << 2);

  im_addr_t pc_q, pc_d;
  im_addr_t pc_plus4;
  logic     fetch_err;
  if_id_t   cap;
  if_id_t   id;

  assign pc_plus4  = pc_q + 32'd4;
  assign fetch_err = fetch_fault(pc_q, START_ADDR, END_ADDR);

  // A redirect always wins so a taken branch is never dropped during a stall.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.redirect) begin
      pc_d = bus.redirect_target;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= START_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    cap.valid     = 1'b1;
    cap.instr     = fetch_err ? NOP_INSTR : bus.im_data;
    cap.pc        = pc_q;
    cap.pc_plus4  = pc_plus4;
    cap.fetch_err = fetch_err;
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (bus.stall),
    .flush_i (bus.flush),
    .cap_i   (cap),
    .id_o    (id)
  );

  assign bus.im_addr      = pc_q;
  assign bus.im_enable    = rst_n;
  assign bus.id_valid     = id.valid;
  assign bus.id_instr     = id.instr;
  assign bus.id_pc        = id.pc;
  assign bus.id_pc_plus4  = id.pc_plus4;
  assign bus.id_fetch_err = id.fetch_err;

endmodule
